// File: rtl/tqvp_uart_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : tqvp_uart_loader_pkg
// Brief    : Shared state encoding, protocol bytes and status bit indices for
//            the UART loader controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tqvp_uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        DATA   = 3'd2,
        CKSUM  = 3'd3,
        COMMIT = 3'd4,
        RESP   = 3'd5
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_OK         = 1;
    localparam int STAT_CKSUM_ERR  = 2;
    localparam int STAT_TIMEOUT    = 3;
    localparam int STAT_COUNT_LSB  = 4;

endpackage

`default_nettype wire

// File: rtl/tqvp_uart_loader_if.sv
//------------------------------------------------------------------------------
// Module   : tqvp_uart_loader_if
// Brief    : UART rx/tx handshake and instruction-store write port bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tqvp_uart_loader_if;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic       tx_busy;
    logic       tx_wr_en;
    logic [7:0] tx_data;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;

    modport master (
        input  rx_rdy, rx_data, tx_busy,
        output rx_rdy_clr, tx_wr_en, tx_data, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy,
        input  rx_rdy_clr, tx_wr_en, tx_data, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/tqvp_loader_stage_buf.sv
//------------------------------------------------------------------------------
// Module   : tqvp_loader_stage_buf
// Brief    : 16x8 staging buffer, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tqvp_loader_stage_buf (
    input  wire logic       clk,
    input  wire logic       i_we,
    input  wire logic [3:0] i_waddr,
    input  wire logic [7:0] i_wdata,
    input  wire logic [3:0] i_raddr,
    output logic      [7:0] o_rdata
);

    logic [7:0] r_mem [16];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/tqvp_uart_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tqvp_uart_loader_ctrl
// Brief    : Parses framed UART load commands, stages and commits payloads to
//            the instruction store, answers ACK/NAK. Optional checksum byte is
//            enabled by defining UART_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tqvp_uart_loader_ctrl
    import tqvp_uart_loader_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd6400
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          enable,
    input  wire logic          status_clr,
    tqvp_uart_loader_if.master bus,
    output logic               done,
    output logic [7:0]         status
);

    loader_state_e r_state;
    loader_state_e w_state_nxt;

    logic        r_rx_rdy_clr;
    logic [3:0]  r_start;
    logic [3:0]  r_len_m1;
    logic [3:0]  r_idx;
    logic [15:0] r_to_cnt;
    logic [7:0]  r_tx_data;
    logic        r_ok;
    logic        r_to_err;
    logic [3:0]  r_count;

    logic        w_in_frame;
    logic        w_consume;
    logic        w_to_expired;
    logic        w_commit_last;
    logic        w_timeout_hit;
    logic        w_cksum_bad;
    logic        w_cksum_err;
    logic        w_mem_we;
    logic        w_tx_wr_en;
    logic        w_buf_we;
    logic [7:0]  w_buf_rdata;
    logic [7:0]  w_status;

`ifdef UART_LOADER_CKSUM_EN
    logic [7:0]  r_xor;
    logic        r_cksum_err;
    assign w_cksum_err = r_cksum_err;
`else
    assign w_cksum_err = 1'b0;
`endif

    assign w_in_frame   = (r_state == HDR) || (r_state == DATA) || (r_state == CKSUM);
    // Bytes are only taken while parsing; anything arriving in COMMIT/RESP waits in the UART.
    assign w_consume    = bus.rx_rdy && !r_rx_rdy_clr && ((r_state == IDLE) || w_in_frame);
    assign w_to_expired = (TIMEOUT_CYCLES != 16'd0) && (r_to_cnt == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_commit_last = 1'b0;
        w_timeout_hit = 1'b0;
        w_cksum_bad   = 1'b0;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_consume && (bus.rx_data == SYNC_BYTE)) begin
                        w_state_nxt = HDR;
                    end
                end
                HDR: begin
                    if (w_consume) begin
                        w_state_nxt = DATA;
                    end else if (w_to_expired) begin
                        w_state_nxt   = RESP;
                        w_timeout_hit = 1'b1;
                    end
                end
                DATA: begin
                    if (w_consume) begin
                        if (r_idx == r_len_m1) begin
`ifdef UART_LOADER_CKSUM_EN
                            w_state_nxt = CKSUM;
`else
                            w_state_nxt = COMMIT;
`endif
                        end
                    end else if (w_to_expired) begin
                        w_state_nxt   = RESP;
                        w_timeout_hit = 1'b1;
                    end
                end
`ifdef UART_LOADER_CKSUM_EN
                CKSUM: begin
                    if (w_consume) begin
                        if (bus.rx_data == r_xor) begin
                            w_state_nxt = COMMIT;
                        end else begin
                            w_state_nxt = RESP;
                            w_cksum_bad = 1'b1;
                        end
                    end else if (w_to_expired) begin
                        w_state_nxt   = RESP;
                        w_timeout_hit = 1'b1;
                    end
                end
`endif
                COMMIT: begin
                    if (r_idx == r_len_m1) begin
                        w_state_nxt   = RESP;
                        w_commit_last = 1'b1;
                    end
                end
                RESP: begin
                    if (!bus.tx_busy) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_rdy_clr <= 1'b0;
            r_start      <= 4'h0;
            r_len_m1     <= 4'h0;
            r_idx        <= 4'h0;
            r_to_cnt     <= 16'h0000;
            r_tx_data    <= 8'h00;
            r_ok         <= 1'b0;
            r_to_err     <= 1'b0;
            r_count      <= 4'h0;
        end else begin
            r_rx_rdy_clr <= w_consume;

            if (w_consume || !w_in_frame) begin
                r_to_cnt <= 16'h0000;
            end else if (r_to_cnt != 16'hFFFF) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            if ((r_state == HDR) && w_consume) begin
                r_start  <= bus.rx_data[7:4];
                r_len_m1 <= bus.rx_data[3:0];
            end

            // The same index walks the staging buffer while filling and while committing.
            if (r_state != w_state_nxt) begin
                r_idx <= 4'h0;
            end else if (((r_state == DATA) && w_consume) || (r_state == COMMIT)) begin
                r_idx <= r_idx + 4'd1;
            end

            if (w_commit_last) begin
                r_ok      <= 1'b1;
                r_count   <= r_count + 4'd1;
                r_tx_data <= ACK_BYTE;
            end else if (w_timeout_hit || w_cksum_bad) begin
                r_ok      <= 1'b0;
                r_tx_data <= NAK_BYTE;
            end

            // A fresh error outranks a simultaneous clear.
            r_to_err <= w_timeout_hit | (r_to_err & ~status_clr);
        end
    end

`ifdef UART_LOADER_CKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor       <= 8'h00;
            r_cksum_err <= 1'b0;
        end else begin
            if ((r_state == HDR) && w_consume) begin
                r_xor <= bus.rx_data;
            end else if ((r_state == DATA) && w_consume) begin
                r_xor <= r_xor ^ bus.rx_data;
            end
            r_cksum_err <= w_cksum_bad | (r_cksum_err & ~status_clr);
        end
    end
`endif

    assign w_buf_we = (r_state == DATA) && w_consume;

    tqvp_loader_stage_buf u_stage_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_idx),
        .i_wdata (bus.rx_data),
        .i_raddr (r_idx),
        .o_rdata (w_buf_rdata)
    );

    assign w_mem_we   = enable && (r_state == COMMIT);
    assign w_tx_wr_en = enable && (r_state == RESP) && !bus.tx_busy;

    assign bus.rx_rdy_clr = r_rx_rdy_clr;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_we ? (r_start + r_idx) : 4'h0;
    assign bus.mem_wdata  = w_mem_we ? w_buf_rdata : 8'h00;
    assign bus.tx_wr_en   = w_tx_wr_en;
    assign bus.tx_data    = r_tx_data;
    assign done           = w_tx_wr_en && (r_tx_data == ACK_BYTE);

    always_comb begin
        w_status                           = 8'h00;
        w_status[STAT_BUSY]                = (r_state != IDLE);
        w_status[STAT_OK]                  = r_ok;
        w_status[STAT_CKSUM_ERR]           = w_cksum_err;
        w_status[STAT_TIMEOUT]             = r_to_err;
        w_status[STAT_COUNT_LSB +: 4]      = r_count;
    end

    assign status = w_status;

endmodule

`default_nettype wire

// File: tb/tb_tqvp_uart_loader_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_tqvp_uart_loader_ctrl
// Brief    : Directed self-checking bench for the UART loader controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tqvp_uart_loader_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       status_clr;
    logic       done;
    logic [7:0] status;

    tqvp_uart_loader_if lif ();

    tqvp_uart_loader_ctrl #(
        .TIMEOUT_CYCLES (16'd40)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .status_clr (status_clr),
        .bus        (lif.master),
        .done       (done),
        .status     (status)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int tx_cnt      = 0;
    int done_cnt    = 0;
    logic [3:0] wa_log [64];
    logic [7:0] wd_log [64];
    logic [7:0] tx_last = 8'h00;

    always @(negedge clk) begin
        if (lif.mem_we) begin
            wa_log[6'(we_cnt)] = lif.mem_addr;
            wd_log[6'(we_cnt)] = lif.mem_wdata;
            we_cnt = we_cnt + 1;
        end
        if (lif.tx_wr_en) begin
            tx_cnt  = tx_cnt + 1;
            tx_last = lif.tx_data;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one byte and returns just after the edge that consumed it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        @(posedge clk);
        #2;
        lif.rx_data = b;
        lif.rx_rdy  = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!lif.rx_rdy_clr && (n < 300));
        if (!lif.rx_rdy_clr) begin
            check1("rx_consume", lif.rx_rdy_clr, 1'b1);
        end
        lif.rx_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (status[0] && (n < 500));
        if (status[0]) begin
            check1("idle_wait", status[0], 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int w0, t0, d0;

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        status_clr  = 1'b0;
        lif.rx_rdy  = 1'b0;
        lif.rx_data = 8'h00;
        lif.tx_busy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check8("rst_status",     status,               8'h00);
        check8("rst_tx_data",    lif.tx_data,          8'h00);
        check1("rst_tx_wr_en",   lif.tx_wr_en,         1'b0);
        check1("rst_mem_we",     lif.mem_we,           1'b0);
        check8("rst_mem_addr",   {4'h0, lif.mem_addr}, 8'h00);
        check1("rst_rx_rdy_clr", lif.rx_rdy_clr,       1'b0);
        check1("rst_done",       done,                 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Frame A: start 2, len 2
        w0 = we_cnt; t0 = tx_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h21);
        send_byte(8'h11);
        send_byte(8'h22);
`ifdef UART_LOADER_CKSUM_EN
        send_byte(8'h12);
`endif
        check1("a_commit_start", lif.mem_we,            1'b1);
        check8("a_first_addr",   {4'h0, lif.mem_addr},  8'h02);
        check8("a_first_data",   lif.mem_wdata,         8'h11);
        wait_idle();
        checki("a_we_count",  we_cnt - w0,   2);
        check8("a_wa0",       {4'h0, wa_log[6'(w0)]},     8'h02);
        check8("a_wd0",       wd_log[6'(w0)],             8'h11);
        check8("a_wa1",       {4'h0, wa_log[6'(w0 + 1)]}, 8'h03);
        check8("a_wd1",       wd_log[6'(w0 + 1)],         8'h22);
        checki("a_tx_count",  tx_cnt - t0,   1);
        check8("a_tx_byte",   tx_last,       8'h06);
        checki("a_done",      done_cnt - d0, 1);
        check8("a_status",    status,        8'h12);

`ifdef UART_LOADER_CKSUM_EN
        // Bad checksum
        w0 = we_cnt; t0 = tx_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h21);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h13);
        wait_idle();
        checki("nak_we_count", we_cnt - w0,   0);
        checki("nak_tx_count", tx_cnt - t0,   1);
        check8("nak_tx_byte",  tx_last,       8'h15);
        checki("nak_done",     done_cnt - d0, 0);
        check8("nak_status",   status,        8'h14);
`endif

        // Wrap-around: start E, len 3
        w0 = we_cnt; t0 = tx_cnt;
        send_byte(8'hA5);
        send_byte(8'hE2);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
`ifdef UART_LOADER_CKSUM_EN
        send_byte(8'hE2);
`endif
        wait_idle();
        checki("wrap_we_count", we_cnt - w0, 3);
        check8("wrap_wa0", {4'h0, wa_log[6'(w0)]},     8'h0E);
        check8("wrap_wd0", wd_log[6'(w0)],             8'h01);
        check8("wrap_wa1", {4'h0, wa_log[6'(w0 + 1)]}, 8'h0F);
        check8("wrap_wd1", wd_log[6'(w0 + 1)],         8'h02);
        check8("wrap_wa2", {4'h0, wa_log[6'(w0 + 2)]}, 8'h00);
        check8("wrap_wd2", wd_log[6'(w0 + 2)],         8'h03);
        check8("wrap_tx_byte", tx_last, 8'h06);
`ifdef UART_LOADER_CKSUM_EN
        check8("wrap_status", status, 8'h26);
`else
        check8("wrap_status", status, 8'h22);
`endif

        // Timeout mid-payload
        w0 = we_cnt; t0 = tx_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h21);
        send_byte(8'h11);
        for (int i = 0; i < 300; i++) begin
            if (tx_cnt != t0) break;
            @(posedge clk);
            #1;
        end
        checki("to_tx_count",  tx_cnt - t0,   1);
        check8("to_tx_byte",   tx_last,       8'h15);
        checki("to_we_count",  we_cnt - w0,   0);
        checki("to_done",      done_cnt - d0, 0);
        wait_idle();
`ifdef UART_LOADER_CKSUM_EN
        check8("to_status", status, 8'h2C);
`else
        check8("to_status", status, 8'h28);
`endif
        @(posedge clk);
        #2;
        status_clr = 1'b1;
        @(posedge clk);
        #2;
        status_clr = 1'b0;
        check8("clr_status", status, 8'h20);

        // Transmitter busy for 100 cycles after a valid frame
        @(posedge clk);
        #2;
        lif.tx_busy = 1'b1;
        w0 = we_cnt; t0 = tx_cnt; d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h5A);
`ifdef UART_LOADER_CKSUM_EN
        send_byte(8'h4A);
`endif
        repeat (100) @(posedge clk);
        #1;
        checki("busy_tx_held",  tx_cnt - t0, 0);
        check1("busy_in_resp",  status[0],   1'b1);
        checki("busy_we_count", we_cnt - w0, 1);
        check8("busy_wa0",      {4'h0, wa_log[6'(w0)]}, 8'h01);
        check8("busy_wd0",      wd_log[6'(w0)],         8'h5A);
        @(posedge clk);
        #2;
        lif.tx_busy = 1'b0;
        #1;
        check1("busy_release_wr", lif.tx_wr_en, 1'b1);
        check1("busy_release_done", done,       1'b1);
        check8("busy_tx_data",    lif.tx_data,  8'h06);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        checki("busy_tx_count",   tx_cnt - t0,   1);
        checki("busy_done_count", done_cnt - d0, 1);
        check8("busy_status",     status,        8'h32);

        // Disabled: noise plus a whole frame are drained and ignored
        @(posedge clk);
        #2;
        enable = 1'b0;
        w0 = we_cnt; t0 = tx_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'h77);
`ifdef UART_LOADER_CKSUM_EN
        send_byte(8'h47);
`endif
        repeat (5) @(posedge clk);
        #1;
        checki("dis_we_count", we_cnt - w0, 0);
        checki("dis_tx_count", tx_cnt - t0, 0);
        check8("dis_status",   status,      8'h32);

        enable = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'h77);
`ifdef UART_LOADER_CKSUM_EN
        send_byte(8'h47);
`endif
        wait_idle();
        checki("en_we_count", we_cnt - w0, 1);
        check8("en_wa0",      {4'h0, wa_log[6'(w0)]}, 8'h03);
        check8("en_wd0",      wd_log[6'(w0)],         8'h77);
        checki("en_tx_count", tx_cnt - t0, 1);
        check8("en_tx_byte",  tx_last,     8'h06);
        check8("en_status",   status,      8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tqvp_uart_loader_ctrl.md
# tqvp_uart_loader_ctrl

Frame-level controller that sequences the peripheral's shared UART and its 16-byte instruction store. It consumes bytes from the UART receiver and parses framed load commands. Payloads are staged, validated, and then committed to the store. The block answers each frame with an ACK or NAK byte through the UART transmitter. It sits between the UART core (rdy/rdy_clr/dout, wr_en/din/tx_busy) and the store's write port, and exposes a status byte to the CPU register map.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd6400 — inter-byte timeout in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  project clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  loader armed; when low the FSM is held in IDLE and received bytes are drained and discarded
- status_clr  in  1  one-cycle pulse; clears the sticky error bits
- rx_rdy  in  1  UART received byte valid
- rx_data  in  8  UART received byte
- rx_rdy_clr  out  1  one-cycle pulse; consumes rx_data
- tx_busy  in  1  UART transmitter busy
- tx_wr_en  out  1  one-cycle pulse; launches tx_data
- tx_data  out  8  response byte
- mem_we  out  1  store write strobe
- mem_addr  out  4  store write address
- mem_wdata  out  8  store write data
- done  out  1  one-cycle pulse when a frame is committed
- status  out  8  [0] busy (FSM not IDLE), [1] last frame OK, [2] checksum error (sticky), [3] timeout error (sticky), [7:4] count of committed frames mod 16

## Operation
- Frame format: SYNC 0xA5, then HDR (bits [7:4] start address, bits [3:0] len−1, so 1–16 bytes), then len payload bytes, then CKSUM when configured.
- Byte consume rule: a byte is consumed when rx_rdy && !rx_rdy_clr. rx_rdy_clr is a registered one-cycle pulse. This prevents consuming the same byte twice.
- FSM states:
  - IDLE: a consumed byte equal to 0xA5 moves to HDR; any other byte is discarded.
  - HDR: latch start address and length, initialise the running XOR to the HDR value, move to DATA.
  - DATA: store each byte in the staging buffer at index 0..len−1 and XOR it into the checksum. After the last byte, move to CKSUM (macro defined) or COMMIT.
  - CKSUM: if the consumed byte equals the running XOR, move to COMMIT. Otherwise set status[2], clear status[1], and go to RESP with NAK 0x15.
  - COMMIT: write one byte per cycle: mem_addr = (start + i) mod 16, for i = 0..len−1. Then set status[1], increment status[7:4] (wraps 15→0), and go to RESP with ACK 0x06.
  - RESP: wait until tx_busy is low, pulse tx_wr_en for one cycle, return to IDLE.
- Address wrap-around: a frame starting at 0xE with length 3 writes 0xE, 0xF, 0x0.
- The store is never written on NAK or timeout. Staging isolates partial frames.
- Timeout: a counter restarts on every consumed byte while in HDR, DATA or CKSUM. When it reaches TIMEOUT_CYCLES: set status[3], clear status[1], go to RESP with NAK.
- Bytes that arrive during COMMIT or RESP stay pending in the UART. They are consumed only after the FSM returns to IDLE.
- enable deasserted mid-frame: abort to IDLE next cycle, no write, no response, no flag change.
- status_clr coinciding with a new error: the new error wins, so the bit stays set.

## Timing
- Reset values: all outputs 0; tx_data 0; FSM in IDLE; counters and flags 0.
- rx_rdy_clr asserts the cycle after rx_rdy is seen and holds for exactly one cycle.
- COMMIT begins the cycle after the final byte (CKSUM byte, or last payload byte when the checksum is compiled out) is consumed. mem_we is high for exactly len consecutive cycles.
- tx_wr_en asserts no earlier than the cycle after COMMIT ends, and only in a cycle where tx_busy = 0. tx_data is stable from RESP entry through the tx_wr_en cycle.
- done pulses in the same cycle as the ACK tx_wr_en; it never pulses for NAK.
- Asynchronous reset mid-COMMIT stops mem_we immediately. Any bytes already written stay in the store.

## Configuration
- UART_LOADER_CKSUM_EN defined: the CKSUM byte is required and checked; NAK is sent on mismatch.
- UART_LOADER_CKSUM_EN undefined: no CKSUM byte; DATA goes directly to COMMIT; status[2] is tied to 0; NAK is sent only on timeout.

## Structure
- Shared package tqvp_uart_loader_pkg holds:
  - the state encoding (IDLE, HDR, DATA, CKSUM, COMMIT, RESP);
  - constants SYNC_BYTE 8'hA5, ACK_BYTE 8'h06, NAK_BYTE 8'h15;
  - status bit index constants.
- One sub-module, tqvp_loader_stage_buf: a 16×8 staging buffer with one synchronous write port and one asynchronous read port.

## Test plan
- Frame A5 21 11 22 12 with the checksum enabled → mem writes addr2=0x11, addr3=0x22; tx_data 0x06; done pulse; status = 0x12.
- Frame A5 21 11 22 13 → no mem_we; NAK 0x15 sent; status[2]=1; status[1]=0; frame count unchanged.
- Frame A5 E2 01 02 03 (checksum compiled out) → writes addr 0xE, 0xF, 0x0 with 01, 02, 03; ACK sent.
- Frame A5 21 11, then silence for TIMEOUT_CYCLES → NAK sent; status[3]=1; no mem_we. Then pulse status_clr → status[3]=0.
- Hold tx_busy high for 100 cycles after a valid frame → tx_wr_en fires exactly once, in the first cycle tx_busy is low.
- Noise bytes 00 FF, then a valid frame, with enable low for the first frame → first frame ignored; second frame (enable high) ACKed.
